// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC stored-program machine: opcodes, sequencer
// states, bus select codes and the register-load decode helper.
package risc_spm_pkg;

  localparam int WORD_WIDTH = 8;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [3:0] {
    S_idle = 4'd0,
    S_fet1 = 4'd1,
    S_fet2 = 4'd2,
    S_dec  = 4'd3,
    S_ex1  = 4'd4,
    S_rd1  = 4'd5,
    S_rd2  = 4'd6,
    S_wr1  = 4'd7,
    S_wr2  = 4'd8,
    S_br1  = 4'd9,
    S_br2  = 4'd10,
    S_halt = 4'd11
  } state_t;

  localparam logic [2:0] BUS1_R0 = 3'd0;
  localparam logic [2:0] BUS1_R1 = 3'd1;
  localparam logic [2:0] BUS1_R2 = 3'd2;
  localparam logic [2:0] BUS1_R3 = 3'd3;
  localparam logic [2:0] BUS1_PC = 3'd4;

  localparam logic [1:0] BUS2_ALU  = 2'd0;
  localparam logic [1:0] BUS2_BUS1 = 2'd1;
  localparam logic [1:0] BUS2_MEM  = 2'd2;

  // One-hot general-register load mask for a 2-bit register index.
  function automatic logic [3:0] reg_load_mask(input logic [1:0] idx);
    logic [3:0] mask;
    case (idx)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0010;
      2'd2:    mask = 4'b0100;
      2'd3:    mask = 4'b1000;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the RISC stored-program machine.
// Optional macro ILLEGAL_AS_NOP_EN: opcodes 9..14 decode as NOP instead of halting.
module control_unit
  import risc_spm_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] instruction,
  input  logic                  zero,
  output logic                  Load_R0,
  output logic                  Load_R1,
  output logic                  Load_R2,
  output logic                  Load_R3,
  output logic                  Load_PC,
  output logic                  Inc_PC,
  output logic                  Load_IR,
  output logic                  Load_Add_R,
  output logic                  Load_Reg_Y,
  output logic                  Load_Reg_Z,
  output logic [2:0]            Sel_Bus_1_Mux,
  output logic [1:0]            Sel_Bus_2_Mux,
  output logic                  write
);

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  load_r_s;
  logic [3:0]  opcode_s;
  logic [1:0]  src_s;
  logic [1:0]  dest_s;

  assign opcode_s = instruction[WORD_WIDTH-1 -: 4];
  assign src_s    = instruction[3:2];
  assign dest_s   = instruction[1:0];

  assign Load_R0 = load_r_s[0];
  assign Load_R1 = load_r_s[1];
  assign Load_R2 = load_r_s[2];
  assign Load_R3 = load_r_s[3];

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_idle;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and strobe decode; reset low silences every output immediately.
  always_comb begin
    next_state_s  = S_idle;
    load_r_s      = 4'b0000;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    Sel_Bus_1_Mux = BUS1_R0;
    Sel_Bus_2_Mux = BUS2_ALU;
    write         = 1'b0;

    if (rst) begin
      case (state_r)
        S_idle: begin
          next_state_s = S_fet1;
        end
        S_fet1: begin
          Sel_Bus_1_Mux = BUS1_PC;
          Sel_Bus_2_Mux = BUS2_BUS1;
          Load_Add_R    = 1'b1;
          Inc_PC        = 1'b1;
          next_state_s  = S_fet2;
        end
        S_fet2: begin
          Sel_Bus_2_Mux = BUS2_MEM;
          Load_IR       = 1'b1;
          next_state_s  = S_dec;
        end
        S_dec: begin
          case (opcode_s)
            OP_NOP: begin
              next_state_s = S_fet1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              Sel_Bus_1_Mux = {1'b0, src_s};
              Sel_Bus_2_Mux = BUS2_BUS1;
              Load_Reg_Y    = 1'b1;
              next_state_s  = S_ex1;
            end
            OP_NOT: begin
              Sel_Bus_1_Mux = {1'b0, src_s};
              Sel_Bus_2_Mux = BUS2_ALU;
              Load_Reg_Z    = 1'b1;
              load_r_s      = reg_load_mask(dest_s);
              next_state_s  = S_fet1;
            end
            OP_RD: begin
              Sel_Bus_1_Mux = BUS1_PC;
              Sel_Bus_2_Mux = BUS2_BUS1;
              Load_Add_R    = 1'b1;
              next_state_s  = S_rd1;
            end
            OP_WR: begin
              Sel_Bus_1_Mux = BUS1_PC;
              Sel_Bus_2_Mux = BUS2_BUS1;
              Load_Add_R    = 1'b1;
              next_state_s  = S_wr1;
            end
            OP_BR: begin
              Sel_Bus_1_Mux = BUS1_PC;
              Sel_Bus_2_Mux = BUS2_BUS1;
              Load_Add_R    = 1'b1;
              next_state_s  = S_br1;
            end
            OP_BRZ: begin
              if (zero) begin
                Sel_Bus_1_Mux = BUS1_PC;
                Sel_Bus_2_Mux = BUS2_BUS1;
                Load_Add_R    = 1'b1;
                next_state_s  = S_br1;
              end else begin
                // Not taken: step the PC over the address byte.
                Inc_PC       = 1'b1;
                next_state_s = S_fet1;
              end
            end
            OP_HLT: begin
              next_state_s = S_halt;
            end
            default: begin
`ifdef ILLEGAL_AS_NOP_EN
              next_state_s = S_fet1;
`else
              next_state_s = S_halt;
`endif
            end
          endcase
        end
        S_ex1: begin
          Sel_Bus_1_Mux = {1'b0, dest_s};
          Sel_Bus_2_Mux = BUS2_ALU;
          Load_Reg_Z    = 1'b1;
          load_r_s      = reg_load_mask(dest_s);
          next_state_s  = S_fet1;
        end
        S_rd1: begin
          Sel_Bus_2_Mux = BUS2_MEM;
          Load_Add_R    = 1'b1;
          Inc_PC        = 1'b1;
          next_state_s  = S_rd2;
        end
        S_rd2: begin
          Sel_Bus_2_Mux = BUS2_MEM;
          load_r_s      = reg_load_mask(dest_s);
          next_state_s  = S_fet1;
        end
        S_wr1: begin
          Sel_Bus_2_Mux = BUS2_MEM;
          Load_Add_R    = 1'b1;
          Inc_PC        = 1'b1;
          next_state_s  = S_wr2;
        end
        S_wr2: begin
          Sel_Bus_1_Mux = {1'b0, src_s};
          write         = 1'b1;
          next_state_s  = S_fet1;
        end
        S_br1: begin
          Sel_Bus_2_Mux = BUS2_MEM;
          Load_Add_R    = 1'b1;
          next_state_s  = S_br2;
        end
        S_br2: begin
          Sel_Bus_2_Mux = BUS2_MEM;
          Load_PC       = 1'b1;
          next_state_s  = S_fet1;
        end
        S_halt: begin
          next_state_s = S_halt;
        end
        default: begin
          next_state_s = S_idle;
        end
      endcase
    end else begin
      next_state_s = S_idle;
    end
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction-sequencing FSM for the 8-bit RISC stored-program machine.
- Decodes the fetched instruction and the registered zero flag.
- Drives every load, increment, bus-select and memory-write strobe of the processing unit.
- Sits beside the processing unit and memory at top level; one instruction completes per 3–5 clocks.

Parameters:
- WORD_WIDTH, 8, instruction/data word width; opcode = [7:4], src = [3:2], dest = [1:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- instruction  input  WORD_WIDTH  IR contents
- zero  input  1  registered Z flag from datapath
- Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  general register loads
- Load_PC  output  1  PC parallel load from Bus_2
- Inc_PC  output  1  PC increment
- Load_IR  output  1  instruction register load
- Load_Add_R  output  1  memory address register load
- Load_Reg_Y  output  1  ALU operand register load
- Load_Reg_Z  output  1  zero-flag register load
- Sel_Bus_1_Mux  output  3  0..3 = R0..R3, 4 = PC
- Sel_Bus_2_Mux  output  2  0 = ALU, 1 = Bus_1, 2 = memory word
- write  output  1  memory write strobe (address = Add_R, data = Bus_1)

Behaviour:
- Reset: sync active-low. A clk edge with rst==0 puts state in S_idle.
- While rst==0, all outputs are forced to 0 combinationally, so reset mid-instruction issues no write or load.
- Outputs are decoded combinationally from state, opcode, src, dest and zero. Each strobe lasts exactly one cycle. Unlisted outputs are 0.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, HLT=15, others illegal.
- RD, WR, BR and BRZ are two-byte instructions; the second byte is the address.
- S_idle: no strobes -> S_fet1.
- S_fet1: Sel1=PC, Sel2=1, Load_Add_R, Inc_PC -> S_fet2.
- S_fet2: Sel2=2, Load_IR -> S_dec.
- S_dec, by opcode:
  - NOP: -> S_fet1.
  - ADD/SUB/AND: Sel1=src, Sel2=1, Load_Reg_Y -> S_ex1.
  - NOT: Sel1=src, Sel2=0, Load_Reg_Z, Load_R[dest] -> S_fet1.
  - RD/WR/BR: Sel1=PC, Sel2=1, Load_Add_R -> S_rd1/S_wr1/S_br1 respectively.
  - BRZ with zero=1: as BR -> S_br1.
  - BRZ with zero=0: Inc_PC (skip address byte) -> S_fet1.
  - HLT or illegal: -> S_halt.
- S_ex1: Sel1=dest, Sel2=0, Load_Reg_Z, Load_R[dest] -> S_fet1.
- S_rd1 / S_wr1: Sel2=2, Load_Add_R, Inc_PC -> S_rd2 / S_wr2.
- S_rd2: Sel2=2, Load_R[dest] -> S_fet1.
- S_wr2: Sel1=src, write=1 -> S_fet1.
- S_br1: Sel2=2, Load_Add_R -> S_br2.
- S_br2: Sel2=2, Load_PC -> S_fet1.
- S_halt: all outputs 0; absorbing; exit only via reset.
- zero is sampled only in S_dec for BRZ.
- Undefined state encodings recover to S_idle next cycle.
- Latency in clocks, including fetch:
  - NOP: 3.
  - NOT: 3.
  - ALU ops: 4.
  - BRZ not taken: 3.
  - RD/WR/BR/BRZ taken: 5.

Optional Feature:
- Macro: ILLEGAL_AS_NOP_EN.
- Defined: opcodes 9–14 decode as NOP (-> S_fet1); only HLT enters S_halt.
- Undefined: opcodes 9–14 and HLT all enter S_halt.

Decomposition:
- Package risc_spm_pkg holds:
  - Opcode constants.
  - State enum (4-bit, 12 states).
  - Bus_1 select codes (R0..R3, PC).
  - Bus_2 select codes (ALU, BUS1, MEM).
- No sub-module; a single registered-state/combinational-output FSM is natural.

Test Plan:
- Reset then run with instruction=8'h00:
  - S_idle -> S_fet1 -> S_fet2 -> S_dec -> S_fet1.
  - Inc_PC high once every 3 clocks.
  - write never asserted.
- instruction=8'h16 (ADD src=R1, dest=R2):
  - S_dec: Sel1=1, Load_Reg_Y.
  - S_ex1: Sel1=2, Sel2=0, Load_R2=1, Load_Reg_Z=1.
  - Fetch resumes next cycle.
- instruction=8'h6C (WR src=R3):
  - Sequence S_wr1 then S_wr2.
  - write=1 for exactly one cycle with Sel1=3.
  - Inc_PC asserted in S_fet1 and S_wr1 only.
- instruction=8'h80:
  - zero=0: Inc_PC in S_dec, Load_PC never asserted, back to S_fet1.
  - zero=1: Load_PC asserted in S_br2.
- instruction=8'hF0 -> S_halt, all outputs stay 0 for 20 cycles.
- instruction=8'h90 -> S_halt without the macro; NOP behaviour with it.
- Reset mid-op: rst=0 during S_wr2 -> write=0 that cycle, state=S_idle after the edge, then normal fetch once rst=1.
